// File: rtl/py_lockin_pkg.sv
// Shared types and field layout for the py lock-in sweep controller.
package py_lockin_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, EMIT} sweep_state_e;

  // Config word layout
  localparam int unsigned CFG_START_BIT     = 0;
  localparam int unsigned CFG_ABORT_BIT     = 1;
  localparam int unsigned CFG_LOOP_BIT      = 2;
  localparam int unsigned CFG_NUM_STEPS_LSB = 32;
  localparam int unsigned CFG_SETTLE_LSB    = 64;
  localparam int unsigned CFG_PH_START_LSB  = 128;
  localparam int unsigned CFG_PH_STEP_LSB   = 192;

  // Result beat layout, {step, a2, x, y} MSB first
  localparam int unsigned RES_WIDTH    = 128;
  localparam int unsigned RES_Y_LSB    = 0;
  localparam int unsigned RES_X_LSB    = 32;
  localparam int unsigned RES_A2_LSB   = 64;
  localparam int unsigned RES_STEP_LSB = 112;
  localparam int unsigned RES_XY_W     = 32;
  localparam int unsigned RES_A2_W     = 48;
  localparam int unsigned RES_STEP_W   = 16;

endpackage

// File: rtl/py_edge_detect.sv
// One-cycle-delay rising-edge detector for a level-type tick such as deci_clk.
module py_edge_detect (
  input  logic a_clk,
  input  logic a_rst,
  input  logic sig,
  output logic rise_c
);

  logic sig_q;

  always_ff @(posedge a_clk) begin
    if (a_rst) sig_q <= 1'b0;
    else       sig_q <= sig;
  end

  assign rise_c = sig & ~sig_q;

endmodule

// File: rtl/py_lockin_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS phase increment, waits for settled
// lock-in results, and emits one {step, a2, x, y} beat per step.
module py_lockin_sweep_ctrl
  import py_lockin_pkg::*;
#(
  parameter int unsigned AM2_DATA_WIDTH        = 48,
  parameter int unsigned XY_WIDTH              = 32,
  parameter int unsigned PHASE_WIDTH           = 48,
  parameter int unsigned STEP_CNT_WIDTH        = 16,
  parameter int unsigned configuration_address = 998
) (
  input  logic                      a_clk,
  input  logic                      a_rst,
  input  logic [31:0]               config_addr,
  input  logic [511:0]              config_data,
  input  logic [AM2_DATA_WIDTH-1:0] S_AXIS_A2_tdata,
  input  logic [XY_WIDTH-1:0]       S_AXIS_X_tdata,
  input  logic [XY_WIDTH-1:0]       S_AXIS_Y_tdata,
  input  logic                      deci_clk,
  output logic [PHASE_WIDTH-1:0]    M_AXIS_DDSPhaseInc_tdata,
  output logic                      M_AXIS_DDSPhaseInc_tvalid,
  output logic [RES_WIDTH-1:0]      M_AXIS_RES_tdata,
  output logic                      M_AXIS_RES_tvalid,
  input  logic                      M_AXIS_RES_tready,
  output logic                      busy,
  output logic [STEP_CNT_WIDTH-1:0] step_index
);

  sweep_state_e              state_q, state_nxt;
  logic [PHASE_WIDTH-1:0]    phase_q, phase_nxt;
  logic [STEP_CNT_WIDTH-1:0] step_q, step_nxt;
  logic [STEP_CNT_WIDTH-1:0] settle_cnt_q, settle_cnt_nxt;
  logic [RES_WIDTH-1:0]      res_q, res_nxt;
  logic                      res_valid_q, res_valid_nxt;
  logic                      abort_pend_q, abort_pend_nxt;
  logic                      busy_q;
  logic [STEP_CNT_WIDTH-1:0] run_num_steps_q, run_num_steps_nxt;
  logic [STEP_CNT_WIDTH-1:0] run_settle_q, run_settle_nxt;
  logic [PHASE_WIDTH-1:0]    run_ph_start_q, run_ph_start_nxt;
  logic [PHASE_WIDTH-1:0]    run_ph_step_q, run_ph_step_nxt;
  logic                      run_loop_q, run_loop_nxt;

  logic                      tick_c;
  logic                      wr_c, start_c, abort_c, handshake_c, last_step_c;
  logic                      cfg_unused;

  py_edge_detect u_tick (
    .a_clk  (a_clk),
    .a_rst  (a_rst),
    .sig    (deci_clk),
    .rise_c (tick_c)
  );

  assign wr_c        = (config_addr == 32'(configuration_address));
  assign start_c     = wr_c & config_data[CFG_START_BIT];
  assign abort_c     = wr_c & config_data[CFG_ABORT_BIT];
  assign handshake_c = res_valid_q & M_AXIS_RES_tready;
  assign last_step_c = ((step_q + STEP_CNT_WIDTH'(1)) == run_num_steps_q);
  assign cfg_unused  = ^config_data;

  // Next-state and datapath update
  always_comb begin
    state_nxt         = state_q;
    phase_nxt         = phase_q;
    step_nxt          = step_q;
    settle_cnt_nxt    = settle_cnt_q;
    res_nxt           = res_q;
    res_valid_nxt     = res_valid_q;
    abort_pend_nxt    = abort_pend_q;
    run_num_steps_nxt = run_num_steps_q;
    run_settle_nxt    = run_settle_q;
    run_ph_start_nxt  = run_ph_start_q;
    run_ph_step_nxt   = run_ph_step_q;
    run_loop_nxt      = run_loop_q;

    unique case (state_q)
      IDLE: begin
        abort_pend_nxt = 1'b0;
        // Sweep parameters are snapshotted only by an accepted start
        if (start_c && !abort_c &&
            (config_data[CFG_NUM_STEPS_LSB +: STEP_CNT_WIDTH] != '0)) begin
          run_num_steps_nxt = config_data[CFG_NUM_STEPS_LSB +: STEP_CNT_WIDTH];
          run_settle_nxt    = config_data[CFG_SETTLE_LSB +: STEP_CNT_WIDTH];
          run_ph_start_nxt  = config_data[CFG_PH_START_LSB +: PHASE_WIDTH];
          run_ph_step_nxt   = config_data[CFG_PH_STEP_LSB +: PHASE_WIDTH];
          run_loop_nxt      = config_data[CFG_LOOP_BIT];
          state_nxt         = LOAD;
        end
      end
      LOAD: begin
        if (abort_c) begin
          state_nxt = IDLE;
        end else begin
          phase_nxt      = run_ph_start_q;
          step_nxt       = '0;
          settle_cnt_nxt = '0;
          state_nxt      = SETTLE;
        end
      end
      SETTLE: begin
        if (abort_c) begin
          state_nxt = IDLE;
        end else if (tick_c) begin
          if (settle_cnt_q == run_settle_q) begin
            res_nxt = '0;
            res_nxt[RES_STEP_LSB +: RES_STEP_W] = RES_STEP_W'(step_q);
            res_nxt[RES_A2_LSB +: RES_A2_W]     = RES_A2_W'(S_AXIS_A2_tdata);
            res_nxt[RES_X_LSB +: RES_XY_W]      = RES_XY_W'(S_AXIS_X_tdata);
            res_nxt[RES_Y_LSB +: RES_XY_W]      = RES_XY_W'(S_AXIS_Y_tdata);
            res_valid_nxt = 1'b1;
            state_nxt     = EMIT;
          end else begin
            settle_cnt_nxt = settle_cnt_q + STEP_CNT_WIDTH'(1);
          end
        end
      end
      EMIT: begin
        // An abort here waits for the beat to drain before stopping
        if (abort_c) abort_pend_nxt = 1'b1;
        if (handshake_c) begin
          res_valid_nxt  = 1'b0;
          abort_pend_nxt = 1'b0;
          if (abort_c || abort_pend_q) begin
            state_nxt = IDLE;
          end else if (last_step_c) begin
            state_nxt = run_loop_q ? LOAD : IDLE;
          end else begin
            step_nxt       = step_q + STEP_CNT_WIDTH'(1);
            phase_nxt      = phase_q + run_ph_step_q;
            settle_cnt_nxt = '0;
            state_nxt      = SETTLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_q         <= IDLE;
      phase_q         <= PHASE_WIDTH'(1);
      step_q          <= '0;
      settle_cnt_q    <= '0;
      res_q           <= '0;
      res_valid_q     <= 1'b0;
      abort_pend_q    <= 1'b0;
      busy_q          <= 1'b0;
      run_num_steps_q <= '0;
      run_settle_q    <= '0;
      run_ph_start_q  <= '0;
      run_ph_step_q   <= '0;
      run_loop_q      <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      phase_q         <= phase_nxt;
      step_q          <= step_nxt;
      settle_cnt_q    <= settle_cnt_nxt;
      res_q           <= res_nxt;
      res_valid_q     <= res_valid_nxt;
      abort_pend_q    <= abort_pend_nxt;
      busy_q          <= (state_nxt != IDLE);
      run_num_steps_q <= run_num_steps_nxt;
      run_settle_q    <= run_settle_nxt;
      run_ph_start_q  <= run_ph_start_nxt;
      run_ph_step_q   <= run_ph_step_nxt;
      run_loop_q      <= run_loop_nxt;
    end
  end

  assign M_AXIS_DDSPhaseInc_tdata  = phase_q;
  assign M_AXIS_DDSPhaseInc_tvalid = 1'b1;
  assign M_AXIS_RES_tdata          = res_q;
  assign M_AXIS_RES_tvalid         = res_valid_q;
  assign busy                      = busy_q;
  assign step_index                = step_q;

endmodule

// File: tb/tb_py_lockin_sweep_ctrl.sv
// Scoreboard bench for py_lockin_sweep_ctrl: expected beats are queued at start.
module tb_py_lockin_sweep_ctrl;

  logic         a_clk;
  logic         a_rst;
  logic [31:0]  config_addr;
  logic [511:0] config_data;
  logic [47:0]  S_AXIS_A2_tdata;
  logic [31:0]  S_AXIS_X_tdata;
  logic [31:0]  S_AXIS_Y_tdata;
  logic         deci_clk;
  logic [47:0]  M_AXIS_DDSPhaseInc_tdata;
  logic         M_AXIS_DDSPhaseInc_tvalid;
  logic [127:0] M_AXIS_RES_tdata;
  logic         M_AXIS_RES_tvalid;
  logic         M_AXIS_RES_tready;
  logic         busy;
  logic [15:0]  step_index;

  typedef struct {
    logic [127:0] data;
    logic [47:0]  phase;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   tick_n = 0;

  py_lockin_sweep_ctrl dut (
    .a_clk                     (a_clk),
    .a_rst                     (a_rst),
    .config_addr               (config_addr),
    .config_data               (config_data),
    .S_AXIS_A2_tdata           (S_AXIS_A2_tdata),
    .S_AXIS_X_tdata            (S_AXIS_X_tdata),
    .S_AXIS_Y_tdata            (S_AXIS_Y_tdata),
    .deci_clk                  (deci_clk),
    .M_AXIS_DDSPhaseInc_tdata  (M_AXIS_DDSPhaseInc_tdata),
    .M_AXIS_DDSPhaseInc_tvalid (M_AXIS_DDSPhaseInc_tvalid),
    .M_AXIS_RES_tdata          (M_AXIS_RES_tdata),
    .M_AXIS_RES_tvalid         (M_AXIS_RES_tvalid),
    .M_AXIS_RES_tready         (M_AXIS_RES_tready),
    .busy                      (busy),
    .step_index                (step_index)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  function automatic logic [47:0] a2_of(int n);
    return 48'h5A00_0000_0000 + 48'(n);
  endfunction
  function automatic logic [31:0] x_of(int n);
    return 32'hC000_0000 + 32'(n * 3);
  endfunction
  function automatic logic [31:0] y_of(int n);
    return 32'h0000_7000 - 32'(n);
  endfunction

  task automatic push_exp(input int step, input logic [47:0] ph, input int n);
    exp_t e;
    e.data  = {16'(step), a2_of(n), x_of(n), y_of(n)};
    e.phase = ph;
    sb.push_back(e);
  endtask

  // Scoreboard check on every accepted beat
  task automatic monitor();
    exp_t e;
    if (M_AXIS_RES_tvalid === 1'b1 && M_AXIS_RES_tready === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat: got tdata=%h phase=%0d, none expected", M_AXIS_RES_tdata, M_AXIS_DDSPhaseInc_tdata);
      end else begin
        e = sb.pop_front();
        if (M_AXIS_RES_tdata !== e.data || M_AXIS_DDSPhaseInc_tdata !== e.phase) begin
          bad++;
          $display("FAIL beat: got tdata=%h phase=%0d, expected tdata=%h phase=%0d", M_AXIS_RES_tdata, M_AXIS_DDSPhaseInc_tdata, e.data, e.phase);
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge a_clk);
    monitor();
    @(posedge a_clk);
    #1;
  endtask

  task automatic set_data();
    tick_n++;
    S_AXIS_A2_tdata = a2_of(tick_n);
    S_AXIS_X_tdata  = x_of(tick_n);
    S_AXIS_Y_tdata  = y_of(tick_n);
  endtask

  task automatic tick(input int gap);
    set_data();
    deci_clk = 1'b1;
    cycle();
    deci_clk = 1'b0;
    repeat (gap) cycle();
  endtask

  task automatic cfg_write(input logic [7:0] ctrl, input logic [15:0] num, input logic [15:0] settle,
                           input logic [47:0] ps, input logic [47:0] st);
    config_data = '0;
    config_data[7:0]     = ctrl;
    config_data[47:32]   = num;
    config_data[79:64]   = settle;
    config_data[175:128] = ps;
    config_data[239:192] = st;
    config_addr = 32'd998;
    cycle();
    config_addr = 32'd0;
  endtask

  task automatic check1(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    a_rst = 1'b1;
    repeat (3) cycle();
    a_rst = 1'b0;
    cycle();
    check1("rst_phase", 128'(M_AXIS_DDSPhaseInc_tdata), 128'd1);
    check1("rst_ph_valid", 128'(M_AXIS_DDSPhaseInc_tvalid), 128'd1);
    check1("rst_tvalid", 128'(M_AXIS_RES_tvalid), 128'd0);
    check1("rst_tdata", M_AXIS_RES_tdata, 128'd0);
    check1("rst_busy", 128'(busy), 128'd0);
    check1("rst_step", 128'(step_index), 128'd0);
  endtask

  task automatic test_basic();
    int n0;
    M_AXIS_RES_tready = 1'b1;
    n0 = tick_n;
    push_exp(0, 48'd1000, n0 + 3);
    push_exp(1, 48'd1010, n0 + 6);
    push_exp(2, 48'd1020, n0 + 9);
    cfg_write(8'h01, 16'd3, 16'd2, 48'd1000, 48'd10);
    cycle();
    check1("basic_busy", 128'(busy), 128'd1);
    check1("basic_phase0", 128'(M_AXIS_DDSPhaseInc_tdata), 128'd1000);
    repeat (9) tick(19);
    check1("basic_done_busy", 128'(busy), 128'd0);
    check1("basic_left", 128'(sb.size()), 128'd0);
    check1("basic_last_step", 128'(step_index), 128'd2);
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    logic         ok;
    M_AXIS_RES_tready = 1'b0;
    cfg_write(8'h01, 16'd2, 16'd0, 48'd2000, 48'd7);
    cycle();
    push_exp(0, 48'd2000, tick_n + 1);
    held = {16'd0, a2_of(tick_n + 1), x_of(tick_n + 1), y_of(tick_n + 1)};
    tick(0);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10 || i == 30) begin
        set_data();
        deci_clk = 1'b1;
      end else begin
        deci_clk = 1'b0;
      end
      cycle();
      if (M_AXIS_RES_tvalid !== 1'b1 || M_AXIS_RES_tdata !== held ||
          M_AXIS_DDSPhaseInc_tdata !== 48'd2000 || busy !== 1'b1) ok = 1'b0;
    end
    deci_clk = 1'b0;
    check1("bp_hold", 128'(ok), 128'd1);
    M_AXIS_RES_tready = 1'b1;
    cycle();
    check1("bp_phase_step", 128'(M_AXIS_DDSPhaseInc_tdata), 128'd2007);
    check1("bp_step_index", 128'(step_index), 128'd1);
    check1("bp_tvalid_drop", 128'(M_AXIS_RES_tvalid), 128'd0);
    push_exp(1, 48'd2007, tick_n + 1);
    tick(19);
    check1("bp_done_busy", 128'(busy), 128'd0);
    check1("bp_left", 128'(sb.size()), 128'd0);
  endtask

  task automatic test_neg_wrap();
    M_AXIS_RES_tready = 1'b1;
    push_exp(0, 48'd5, tick_n + 1);
    push_exp(1, 48'hFFFF_FFFF_FFFB, tick_n + 2);
    cfg_write(8'h01, 16'd2, 16'd0, 48'd5, 48'hFFFF_FFFF_FFF6);
    cycle();
    repeat (2) tick(19);
    check1("wrap_busy", 128'(busy), 128'd0);
    check1("wrap_left", 128'(sb.size()), 128'd0);
  endtask

  task automatic test_abort();
    M_AXIS_RES_tready = 1'b1;
    cfg_write(8'h01, 16'd3, 16'd5, 48'd300, 48'd1);
    cycle();
    repeat (2) tick(19);
    cfg_write(8'h02, 16'd0, 16'd0, 48'd0, 48'd0);
    check1("abort_settle_busy", 128'(busy), 128'd0);
    check1("abort_settle_phase", 128'(M_AXIS_DDSPhaseInc_tdata), 128'd300);
    repeat (6) tick(19);
    M_AXIS_RES_tready = 1'b0;
    push_exp(0, 48'd400, tick_n + 1);
    cfg_write(8'h01, 16'd3, 16'd0, 48'd400, 48'd1);
    cycle();
    tick(3);
    cfg_write(8'h02, 16'd0, 16'd0, 48'd0, 48'd0);
    check1("abort_emit_valid", 128'(M_AXIS_RES_tvalid), 128'd1);
    check1("abort_emit_busy", 128'(busy), 128'd1);
    repeat (5) cycle();
    check1("abort_emit_hold", 128'(M_AXIS_RES_tvalid), 128'd1);
    M_AXIS_RES_tready = 1'b1;
    cycle();
    check1("abort_emit_idle", 128'(busy), 128'd0);
    check1("abort_emit_drop", 128'(M_AXIS_RES_tvalid), 128'd0);
    repeat (3) tick(19);
    check1("abort_left", 128'(sb.size()), 128'd0);
  endtask

  task automatic test_loop();
    M_AXIS_RES_tready = 1'b1;
    push_exp(0, 48'd100, tick_n + 1);
    push_exp(1, 48'd101, tick_n + 2);
    push_exp(0, 48'd100, tick_n + 3);
    push_exp(1, 48'd101, tick_n + 4);
    cfg_write(8'h05, 16'd2, 16'd0, 48'd100, 48'd1);
    cycle();
    repeat (2) tick(19);
    cfg_write(8'h01, 16'd2, 16'd0, 48'd9999, 48'd50);
    repeat (2) tick(19);
    check1("loop_busy", 128'(busy), 128'd1);
    check1("loop_left", 128'(sb.size()), 128'd0);
    cfg_write(8'h02, 16'd0, 16'd0, 48'd0, 48'd0);
    check1("loop_abort_idle", 128'(busy), 128'd0);
    repeat (2) tick(19);
  endtask

  task automatic test_reset_mid();
    M_AXIS_RES_tready = 1'b1;
    push_exp(0, 48'd700, tick_n + 1);
    cfg_write(8'h01, 16'd3, 16'd0, 48'd700, 48'd5);
    cycle();
    tick(19);
    check1("rmid_step", 128'(step_index), 128'd1);
    check1("rmid_phase", 128'(M_AXIS_DDSPhaseInc_tdata), 128'd705);
    a_rst = 1'b1;
    cycle();
    a_rst = 1'b0;
    check1("rmid_phase_rst", 128'(M_AXIS_DDSPhaseInc_tdata), 128'd1);
    check1("rmid_busy", 128'(busy), 128'd0);
    check1("rmid_step_rst", 128'(step_index), 128'd0);
    check1("rmid_tvalid", 128'(M_AXIS_RES_tvalid), 128'd0);
    repeat (2) tick(19);
  endtask

  task automatic test_ignored_starts();
    cfg_write(8'h01, 16'd0, 16'd0, 48'd50, 48'd1);
    cycle();
    check1("zero_steps_idle", 128'(busy), 128'd0);
    cfg_write(8'h03, 16'd2, 16'd0, 48'd50, 48'd1);
    cycle();
    check1("start_abort_idle", 128'(busy), 128'd0);
    config_data = '0;
    config_data[0] = 1'b1;
    config_data[47:32] = 16'd2;
    config_addr = 32'd997;
    cycle();
    config_addr = 32'd0;
    cycle();
    check1("wrong_addr_idle", 128'(busy), 128'd0);
    repeat (2) tick(19);
    check1("final_left", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    a_rst = 1'b1;
    config_addr = '0;
    config_data = '0;
    S_AXIS_A2_tdata = '0;
    S_AXIS_X_tdata = '0;
    S_AXIS_Y_tdata = '0;
    deci_clk = 1'b0;
    M_AXIS_RES_tready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_neg_wrap();
    test_abort();
    test_loop();
    test_reset_mid();
    test_ignored_starts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/py_lockin_sweep_ctrl.md
Name: py_lockin_sweep_ctrl

Overview:
Frequency-sweep sequencer for the py lock-in. It steps the lock-in DDS phase increment from a programmed start value by a signed step. After each step it waits a programmable number of lock-in decimated result ticks so the correlation ring buffer refills. It then captures amplitude², X and Y and emits one result beat per step on an AXI-stream. It sits between the config bus and the lock-in's DDS phase-inc input, and consumes the lock-in's result outputs and decimation clock.

Parameters:
AM2_DATA_WIDTH, 48, width of the lock-in amplitude² input
XY_WIDTH, 32, width of the X and Y inputs
PHASE_WIDTH, 48, width of the DDS phase increment
STEP_CNT_WIDTH, 16, width of the step and settle counters
configuration_address, 998, config bus address of this block

Ports:
a_clk  in  1  system clock
a_rst  in  1  synchronous active-high reset
config_addr  in  32  config bus address
config_data  in  512  config bus data
S_AXIS_A2_tdata  in  AM2_DATA_WIDTH  lock-in amplitude²
S_AXIS_X_tdata  in  XY_WIDTH  lock-in X
S_AXIS_Y_tdata  in  XY_WIDTH  lock-in Y
deci_clk  in  1  lock-in result tick (level; a rising edge means new results)
M_AXIS_DDSPhaseInc_tdata  out  PHASE_WIDTH  phase increment to the DDS
M_AXIS_DDSPhaseInc_tvalid  out  1  always 1
M_AXIS_RES_tdata  out  128  {step[15:0], a2[47:0], x[31:0], y[31:0]}, MSB first
M_AXIS_RES_tvalid  out  1  result beat valid
M_AXIS_RES_tready  in  1  downstream ready
busy  out  1  high whenever state != IDLE
step_index  out  STEP_CNT_WIDTH  current step number

Behaviour:
- Config write: when config_addr == configuration_address, latch the fields in the same cycle:
  - ctrl = data[7:0]: bit0 start (pulse), bit1 abort (pulse), bit2 loop
  - num_steps = data[47:32]
  - settle = data[79:64]
  - ph_start = data[175:128]
  - ph_step = data[239:192], signed
  - start and abort act only in the write cycle. The other fields may be rewritten at any time but are sampled only at START.
- Reset values: phase_inc = 1, tvalid = 0, tdata = 0, busy = 0, step_index = 0, state = IDLE, all counters 0.
- Tick detect: register deci_clk once. tick = deci_clk & ~deci_clk_q. Inputs are sampled in the tick cycle.
- States:
  - IDLE: on start with num_steps != 0 → LOAD. Start with num_steps == 0 is ignored.
  - LOAD (1 cycle): phase_inc <= ph_start, step <= 0, settle_cnt <= 0 → SETTLE.
  - SETTLE: count ticks. On the tick that makes settle_cnt == settle → capture a2/x/y and step into the output register, tvalid <= 1 → EMIT. settle == 0 captures on the first tick after entry.
  - EMIT: hold tdata stable while tvalid & ~tready. On tvalid & tready: tvalid <= 0.
    - If step+1 == num_steps: go to IDLE, or to LOAD if loop = 1.
    - Otherwise: step <= step+1, phase_inc <= phase_inc + ph_step (modulo 2^PHASE_WIDTH, wraps silently), settle_cnt <= 0 → SETTLE.
- Phase change latency: the new phase_inc appears on the output in the cycle after the accepting handshake.
- Ticks in LOAD, EMIT or IDLE are ignored and are not counted.
- Abort:
  - In SETTLE or LOAD: → IDLE next cycle. phase_inc holds its last value.
  - In EMIT: tvalid is never dropped without a handshake. Abort is recorded and the block goes to IDLE after the handshake, with no further step.
  - Start while busy is ignored. If start and abort arrive in the same write, abort wins.
- a_rst mid-operation: next cycle every register is at its reset value, including phase_inc = 1. A pending beat is discarded.
- step_index mirrors step. busy = (state != IDLE).

Decomposition:
- Shared package py_lockin_pkg holds:
  - state enum {IDLE, LOAD, SETTLE, EMIT}
  - config field bit offsets as localparams
  - RES beat field offsets
- One natural sub-module, py_edge_detect: a one-cycle-delay rising-edge detector for deci_clk, reusable by other decimated consumers.

Test Plan:
- Basic sweep: ph_start = 1000, ph_step = 10, num_steps = 3, settle = 2, tready = 1, deci_clk pulse every 20 cycles → three beats.
  - Steps 0, 1, 2 with phase 1000, 1010, 1020.
  - Each beat follows the 3rd tick after entering SETTLE.
  - busy drops after the 3rd handshake.
- Backpressure: hold tready = 0 for 50 cycles in EMIT → tdata and tvalid stable, extra ticks ignored, phase unchanged. Release → the beat is accepted and the phase steps the next cycle.
- Negative wrap: ph_start = 5, ph_step = −10, num_steps = 2 → second phase = 2^48 − 5.
- Abort in SETTLE → IDLE in 1 cycle with no beat. Abort in EMIT with tready = 0 → the beat stays valid, is accepted when tready rises, then IDLE with no further beats.
- Loop mode: num_steps = 2, loop = 1 → beat steps 0, 1, 0, 1…; abort stops it.
- Reset in SETTLE → all outputs at reset values, phase_inc = 1. Start with num_steps = 0 → stays IDLE.
